// File: rtl/bk_accum_stage_pkg.sv
// Shared types and constants for the Brent-Kung frame accumulator stage.
// Also holds the operand interleaving helper used to feed the adder.
package bk_accum_stage_pkg;

  localparam int DATA_W = 12;
  localparam logic [DATA_W-1:0] SAT_VAL = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Adder operand bus layout: bit 2i = a[i], bit 2i+1 = b[i]
  function automatic logic [2*DATA_W-1:0] interleave(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] ab;
    ab = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ab[2*i]   = a[i];
      ab[2*i+1] = b[i];
    end
    return ab;
  endfunction

endpackage

// File: rtl/bk_accum_stage_bk_add.sv
// Combinational N-bit Brent-Kung prefix adder, carry-in 0.
// Operands arrive interleaved; sum[N] is the carry-out.
module bk_accum_stage_bk_add
  import bk_accum_stage_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic [2*N-1:0] ab,
  output logic [N:0]     sum
);

  localparam int LV = $clog2(N);

  logic [N-1:0] hs;
  logic [N-1:0] g;
  logic [N-1:0] p;

  always_comb begin
    hs = '0;
    g  = '0;
    p  = '0;
    for (int i = 0; i < N; i++) begin
      g[i]  = ab[2*i] & ab[2*i+1];
      p[i]  = ab[2*i] ^ ab[2*i+1];
    end
    hs = p;
    // Up-sweep: build group generate/propagate on the power-of-two spine
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (i >= (1 << l)) ? i - (1 << l) : 0;
        if (((i + 1) % (2 << l)) == 0) begin
          g[i] = g[i] | (p[i] & g[j]);
          p[i] = p[i] & p[j];
        end
      end
    end
    // Down-sweep: fill in the remaining prefixes from completed spine nodes
    for (int l = LV - 1; l >= 0; l--) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (i >= (1 << l)) ? i - (1 << l) : 0;
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
          g[i] = g[i] | (p[i] & g[j]);
        end
      end
    end
  end

  assign sum = {g[N-1], hs ^ {g[N-2:0], 1'b0}};

endmodule

// File: rtl/bk_accum_stage.sv
// Frame accumulator: sums 12-bit beats through a Brent-Kung adder, presents
// sum / sticky carry flag / beat count once the last beat of a frame lands.
module bk_accum_stage
  import bk_accum_stage_pkg::*;
#(
  parameter int SATURATE = 1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state;
  logic                rdy_p1;
  logic                vld_p1;
  logic [DATA_W-1:0]   acc_p1;
  logic                ovf_p1;
  logic [CNT_W-1:0]    cnt_p1;

  logic                beat_p0;
  logic [DATA_W-1:0]   opa_p0;
  logic [2*DATA_W-1:0] ab_p0;
  logic [DATA_W:0]     sum_p0;
  logic                carry_p0;

  function automatic logic [DATA_W-1:0] sat_acc(input logic [DATA_W:0] s);
    if ((SATURATE != 0) && s[DATA_W]) return SAT_VAL;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_ONE;
  endfunction

  // Stage p0: operand select and combinational add
  assign beat_p0  = in_valid & rdy_p1;
  assign opa_p0   = (state == ST_IDLE) ? '0 : acc_p1;
  assign ab_p0    = interleave(opa_p0, in_data);
  assign carry_p0 = sum_p0[DATA_W];

  bk_accum_stage_bk_add #(
    .N (DATA_W)
  ) u_add (
    .ab  (ab_p0),
    .sum (sum_p0)
  );

  // Stage p1: frame state and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rdy_p1 <= 1'b1;
      vld_p1 <= 1'b0;
      acc_p1 <= '0;
      ovf_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (beat_p0) begin
            acc_p1 <= sat_acc(sum_p0);
            ovf_p1 <= 1'b0;
            cnt_p1 <= CNT_ONE;
            if (in_last) begin
              state  <= ST_HOLD;
              rdy_p1 <= 1'b0;
              vld_p1 <= 1'b1;
            end else begin
              state  <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (beat_p0) begin
            acc_p1 <= sat_acc(sum_p0);
            ovf_p1 <= ovf_p1 | carry_p0;
            cnt_p1 <= cnt_inc(cnt_p1);
            if (in_last) begin
              state  <= ST_HOLD;
              rdy_p1 <= 1'b0;
              vld_p1 <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state  <= ST_IDLE;
            rdy_p1 <= 1'b1;
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          rdy_p1 <= 1'b1;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = rdy_p1;
  assign out_valid = vld_p1;
  assign out_sum   = acc_p1;
  assign out_ovf   = ovf_p1;
  assign out_count = cnt_p1;

endmodule

// File: tb/tb_bk_accum_stage.sv
// Bench for bk_accum_stage: saturating and wrapping instances share stimulus
// and are checked against a plain-integer frame model.
module tb_bk_accum_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        rdy_s, vld_s, ovf_s;
  logic [11:0] sum_s;
  logic [7:0]  cnt_s;
  logic        rdy_w, vld_w, ovf_w;
  logic [11:0] sum_w;
  logic [7:0]  cnt_w;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned q[$];

  always #5 clk = ~clk;

  bk_accum_stage #(.SATURATE(1), .CNT_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_s), .out_ready(out_ready),
    .out_sum(sum_s), .out_ovf(ovf_s), .out_count(cnt_s)
  );

  bk_accum_stage #(.SATURATE(0), .CNT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w),
    .in_data(in_data), .in_last(in_last), .out_valid(vld_w), .out_ready(out_ready),
    .out_sum(sum_w), .out_ovf(ovf_w), .out_count(cnt_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unbounded integer sum, fold back on overflow per mode
  function automatic void model(input bit sat, output int unsigned s,
                                output bit ovf, output int unsigned cnt);
    s = 0; ovf = 1'b0; cnt = 0;
    foreach (q[k]) begin
      s = s + q[k];
      if (s > 4095) begin
        ovf = 1'b1;
        s = sat ? 4095 : s - 4096;
      end
      cnt = (cnt < 255) ? cnt + 1 : 255;
    end
  endfunction

  task automatic beat(input logic [11:0] d, input bit last, input int gap);
    for (int c = 0; c < gap; c++) begin
      in_valid = 1'b0;
      in_data  = 12'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("in_ready", {rdy_s, rdy_w}, 2'b11);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 12'($urandom);
    in_last  = 1'($urandom);
    q.push_back(d);
  endtask

  task automatic expect_result(input string tag, input int hold);
    int unsigned es, ew, ec;
    bit eos, eow;
    model(1'b1, es, eos, ec);
    model(1'b0, ew, eow, ec);
    chk({tag, "/vld"}, {vld_s, vld_w}, 2'b11);
    chk({tag, "/rdy"}, {rdy_s, rdy_w}, 2'b00);
    chk({tag, "/sum_sat"}, sum_s, es);
    chk({tag, "/sum_wrap"}, sum_w, ew);
    chk({tag, "/ovf_sat"}, ovf_s, eos);
    chk({tag, "/ovf_wrap"}, ovf_w, eow);
    chk({tag, "/cnt_sat"}, cnt_s, ec);
    chk({tag, "/cnt_wrap"}, cnt_w, ec);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < hold; c++) begin
      in_data = 12'($urandom);
      in_last = 1'($urandom);
      @(posedge clk); #1;
      chk({tag, "/hold_sat"}, {vld_s, rdy_s, sum_s, ovf_s, cnt_s},
          {1'b1, 1'b0, 12'(es), eos, 8'(ec)});
      chk({tag, "/hold_wrap"}, {vld_w, rdy_w, sum_w, ovf_w, cnt_w},
          {1'b1, 1'b0, 12'(ew), eow, 8'(ec)});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "/release"}, {vld_s, vld_w, rdy_s, rdy_w}, 4'b0011);
    chk({tag, "/no_beat"}, {cnt_s, cnt_w}, {8'(ec), 8'(ec)});
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/outs", {vld_s, vld_w, ovf_s, ovf_w, sum_s, cnt_s, sum_w, cnt_w}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset/rdy", {rdy_s, rdy_w, vld_s, vld_w}, 4'b1100);

    beat(12'h123, 1'b1, 0);
    expect_result("single", 0);

    beat(12'h800, 1'b0, 0);
    beat(12'h700, 1'b0, 1);
    beat(12'h200, 1'b1, 0);
    expect_result("carry", 5);

    beat(12'h0AA, 1'b0, 0);
    beat(12'h055, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    chk("midreset/outs", {vld_s, vld_w, cnt_s, cnt_w, sum_s, sum_w}, 32'h0);
    @(posedge clk); #1;
    chk("midreset/vld", {vld_s, vld_w}, 2'b00);
    rst_n = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("midreset/vld_after", {vld_s, vld_w, rdy_s, rdy_w}, 4'b0011);
    beat(12'h005, 1'b1, 0);
    expect_result("after_reset", 1);

    for (int k = 0; k < 300; k++) beat(12'h000, 1'b0, 0);
    beat(12'h000, 1'b1, 0);
    expect_result("cnt_sat", 2);

    for (int f = 0; f < 40; f++) begin
      int len;
      bit big;
      len = $urandom_range(1, 20);
      big = 1'($urandom);
      for (int k = 0; k < len; k++) begin
        logic [11:0] d;
        d = big ? 12'($urandom_range(1024, 4095)) : 12'($urandom_range(0, 300));
        beat(d, k == len - 1, $urandom_range(0, 2));
      end
      expect_result("random", $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bk_accum_stage.md
BK_ACCUM_STAGE -- requirements
Module: bk_accum_stage

Interface
REQ-001 Parameter SATURATE, default 1: 1 = clamp accumulator at 12'hFFF on carry-out; 0 = wrap modulo 4096.
REQ-002 Parameter CNT_W, default 8: width of the beat counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  stage can accept a beat.
REQ-007 in_data  input  12  unsigned operand beat.
REQ-008 in_last  input  1  marks the final beat of a frame.
REQ-009 out_valid  output  1  frame result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sum  output  12  accumulated frame sum.
REQ-012 out_ovf  output  1  sticky flag: at least one carry-out occurred in the frame.
REQ-013 out_count  output  CNT_W  number of beats accepted in the frame, saturating at all-ones.

Function
REQ-014 States: IDLE (no frame open), ACC (frame open), HOLD (result presented).
REQ-015 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-016 in_ready is 1 in IDLE and ACC and 0 in HOLD.
REQ-017 Every addition uses the 12-bit Brent-Kung adder sub-module, with operand A = accumulator and operand B = in_data; carry = sum bit 12.
REQ-018 Beat accepted in IDLE: operand A is forced to 0; the accumulator takes the sum, ovf is cleared, count is set to 1, and the state goes to ACC, or to HOLD if in_last = 1.
REQ-019 Beat accepted in ACC: the accumulator takes the sum, or 12'hFFF if carry = 1 and SATURATE = 1, or sum[11:0] if SATURATE = 0; ovf |= carry; count increments, saturating.
REQ-020 Once saturated at 12'hFFF, the accumulator stays 12'hFFF for the rest of the frame (SATURATE = 1).
REQ-021 Accepting a beat with in_last = 1 moves the state to HOLD on that edge.
REQ-022 out_valid = 1 exactly in HOLD, so the result appears 1 cycle after the last beat is accepted.
REQ-023 out_sum, out_ovf and out_count are registered and stay stable while out_valid = 1 and out_ready = 0.
REQ-024 HOLD with out_ready = 1 returns to IDLE on that edge; no beat can be accepted in that cycle because in_ready = 0.
REQ-025 ACC with no beat accepted holds all state; frames have no timeout.
REQ-026 Outside HOLD, out_sum, out_ovf and out_count show the in-progress values; consumers qualify them with out_valid.
REQ-027 in_data and in_last are ignored when no beat is accepted.

Reset
REQ-028 While rst_n = 0: state = IDLE, accumulator = 0, ovf = 0, count = 0, out_valid = 0, and in_ready = 1 once rst_n deasserts.
REQ-029 Reset asserted mid-frame or in HOLD discards the frame with no result emitted; the first beat after reset starts a new frame.
REQ-030 Reset deassertion is synchronised externally; the block does not re-synchronise rst_n.

Structure
REQ-031 Shared package holds the state enum (IDLE/ACC/HOLD), the constant DATA_W = 12 and the constant SAT_VAL = 12'hFFF.
REQ-032 One sub-module: the 12-bit Brent-Kung adder, instantiated combinationally with an interleaved operand bus (bit 2i = A[i], bit 2i+1 = B[i]) and a 13-bit sum output.
REQ-033 No other arithmetic operator appears in the datapath except the count increment.

Verification
REQ-034 Single-beat frame 12'h123, last = 1, out_ready = 1 -> next cycle out_valid = 1, sum = 12'h123, ovf = 0, count = 1; IDLE the following cycle.
REQ-035 Frame 12'h800, 12'h700, 12'h200 (last), SATURATE = 1 -> sum = 12'hFFF, ovf = 1, count = 3; with SATURATE = 0 -> sum = 12'h100, ovf = 1.
REQ-036 Result held for 5 cycles with out_ready = 0 -> outputs stable and in_ready = 0 throughout; accepted on out_ready = 1, then IDLE.
REQ-037 rst_n pulsed low after 2 beats of a frame -> no out_valid; a new frame of 12'h005 (last) -> sum = 12'h005, count = 1.
REQ-038 300 beats of 12'h000 then a last beat -> count = 255 (saturated), sum = 0, ovf = 0.
REQ-039 Random frames of 1-20 beats with random in_valid/out_ready gaps -> results match a reference model using the SATURATE semantics.
